// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types and constants for the float divider controller.
//   - state_t : controller FSM states
//   - opcls_t : IEEE-754 single operand class
//   - QNAN/INF canonical encodings, exponent/fraction field widths
//   - op_class() helper that classifies one operand
package fdiv_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} opcls_t;

  // Denormals count as CLS_NORM: they are finite and nonzero, so the
  // datapath handles them.
  function automatic opcls_t op_class(input logic [31:0] x);
    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    e = x[FRAC_W +: EXP_W];
    f = x[FRAC_W-1:0];
    if (e == '1)
      return (f == '0) ? CLS_INF : CLS_NAN;
    else if (e == '0 && f == '0)
      return CLS_ZERO;
    else
      return CLS_NORM;
  endfunction

endpackage

// File: rtl/fdiv_classify.sv
// fdiv_classify: combinational special-operand resolver for a / b.
//   a, b    in  32  dividend, divisor (IEEE-754 single)
//   special out 1   result is fully determined without the datapath
//   z       out 32  canonical result when special
//   nv, dz  out 1   invalid-operation / divide-by-zero flags
module fdiv_classify
  import fdiv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        special,
  output logic [31:0] z,
  output logic        nv,
  output logic        dz
);

  opcls_t ca;
  opcls_t cb;
  logic   s;

  always_comb begin
    ca      = op_class(a);
    cb      = op_class(b);
    s       = a[31] ^ b[31];
    special = 1'b1;
    z       = '0;
    nv      = 1'b0;
    dz      = 1'b0;
    // Invalid cases are checked first so that e.g. inf/inf never falls
    // into the inf/finite branch.
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_ZERO && cb == CLS_ZERO) ||
        (ca == CLS_INF  && cb == CLS_INF)) begin
      z  = QNAN;
      nv = 1'b1;
    end else if (ca == CLS_INF) begin
      z = {s, INF[30:0]};
    end else if (cb == CLS_ZERO) begin
      z  = {s, INF[30:0]};
      dz = 1'b1;
    end else if (cb == CLS_INF || ca == CLS_ZERO) begin
      z = {s, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

endmodule

// File: rtl/fdiv_ctrl.sv
// fdiv_ctrl: round-robin arbiter and sequencer for a shared iterative
// single-precision divider datapath.
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/ready           request handshake, N = 0, 1
//   reqN_a, reqN_b, reqN_tag   dividend, divisor, opaque tag
//   dp_a, dp_b                 datapath operands, change only on acceptance
//   dp_load, dp_step, dp_z     datapath load/step strobes and quotient
//   res_valid/ready            result handshake
//   res_z, res_id, res_tag     quotient, requester index, echoed tag
//   res_nv, res_dz             invalid / divide-by-zero flags
//   busy                       controller not idle
// Build option: define FDIV_CTRL_SPECIAL_EN to resolve NaN/inf/zero operands
// in the controller (one-cycle bypass of the datapath). Without it every
// request is iterated and the flags stay 0.
module fdiv_ctrl
  import fdiv_pkg::*;
#(
  parameter int ITERS = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      dp_a,
  output logic [31:0]      dp_b,
  output logic             dp_load,
  output logic             dp_step,
  input  logic [31:0]      dp_z,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_z,
  output logic             res_id,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_nv,
  output logic             res_dz,
  output logic             busy
);

  if (ITERS < 1 || ITERS > 7) begin : g_bad_iters
    $error("fdiv_ctrl: ITERS must be in 1..7");
  end

  localparam logic [2:0] LAST = 3'(ITERS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             ptr;       // 1: favour req1 on contention
  logic [2:0]       cnt;
  logic             gnt_any;
  logic             gnt_id;
  logic             acc;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic             special;
  logic [31:0]      sp_z;
  logic             sp_nv;
  logic             sp_dz;

  // Grant: a lone requester wins; on contention the pointer decides.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = req1_valid & (~req0_valid | ptr);
    sel_a   = gnt_id ? req1_a   : req0_a;
    sel_b   = gnt_id ? req1_b   : req0_b;
    sel_tag = gnt_id ? req1_tag : req0_tag;
  end

`ifdef FDIV_CTRL_SPECIAL_EN
  fdiv_classify u_classify (
    .a       (sel_a),
    .b       (sel_b),
    .special (special),
    .z       (sp_z),
    .nv      (sp_nv),
    .dz      (sp_dz)
  );
`else
  assign special = 1'b0;
  assign sp_z    = '0;
  assign sp_nv   = 1'b0;
  assign sp_dz   = 1'b0;
`endif

  assign acc = req0_ready | req1_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = special ? DONE : LOAD;
      LOAD:    state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; everything is forced low while rst is high so strobes and
  // handshakes drop in the reset cycle itself.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dp_load    = 1'b0;
    dp_step    = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b0;
    if (!rst) begin
      req0_ready = (state == IDLE) && gnt_any && !gnt_id;
      req1_ready = (state == IDLE) && gnt_any &&  gnt_id;
      dp_load    = (state == LOAD);
      dp_step    = (state == ITER);
      res_valid  = (state == DONE);
      busy       = (state != IDLE);
    end
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= 1'b0;
      cnt     <= '0;
      res_z   <= '0;
      res_id  <= 1'b0;
      res_tag <= '0;
      res_nv  <= 1'b0;
      res_dz  <= 1'b0;
    end else begin
      if (acc) begin
        ptr     <= ~gnt_id;
        res_id  <= gnt_id;
        res_tag <= sel_tag;
        res_z   <= sp_z;      // final only for a bypassed request
        res_nv  <= sp_nv;
        res_dz  <= sp_dz;
      end
      if (state == LOAD)
        cnt <= '0;
      else if (state == ITER && cnt != LAST)
        cnt <= cnt + 3'd1;
      if (state == ITER && cnt == LAST)
        res_z <= dp_z;
    end
  end

  // Operand registers: data only, loaded on acceptance
  always_ff @(posedge clk) begin
    if (acc) begin
      dp_a <= sel_a;
      dp_b <= sel_b;
    end
  end

endmodule

// File: tb/tb_fdiv_ctrl.sv
`timescale 1ns/1ps
module tb_fdiv_ctrl;

  localparam int ITERS = 3;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic [31:0]      dp_a, dp_b, dp_z;
  logic             dp_load, dp_step;
  logic             res_valid, res_ready;
  logic [31:0]      res_z;
  logic             res_id;
  logic [TAG_W-1:0] res_tag;
  logic             res_nv, res_dz, busy;

  always #5 clk = ~clk;

  fdiv_ctrl #(.ITERS(ITERS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_tag(req1_tag),
    .dp_a(dp_a), .dp_b(dp_b), .dp_load(dp_load), .dp_step(dp_step), .dp_z(dp_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_id(res_id),
    .res_tag(res_tag), .res_nv(res_nv), .res_dz(res_dz), .busy(busy)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct {
    logic [31:0]      z;
    logic             id;
    logic [TAG_W-1:0] tag;
    logic             nv;
    logic             dz;
    int               lat;
    int               acc_cyc;
  } exp_t;

  req_t        q0[$], q1[$];
  exp_t        sb[$];
  logic [31:0] zlog[$];
  logic        idlog[$], nvlog[$], dzlog[$], acclog[$];
  logic [TAG_W-1:0] taglog[$];
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0;
  bit          acc0 = 0, acc1 = 0;
  int          rr_mode = 0;  // 0: always ready, 1: random, 2: held low

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Datapath stub: quotient appears only once exactly ITERS steps have run.
  function automatic logic [31:0] dp_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_5A5A;
  endfunction

  int stub_steps;
  always @(posedge clk) begin
    if (rst || dp_load) stub_steps <= 0;
    else if (dp_step)   stub_steps <= stub_steps + 1;
  end
  assign dp_z = ((stub_steps + int'(dp_step)) == ITERS) ? dp_model(dp_a, dp_b) : 32'hDEAD_BEEF;

  // Reference: the quotient a/b as the controller must report it.
  function automatic exp_t model(input req_t r, input logic id, input int c);
    exp_t e;
`ifdef FDIV_CTRL_SPECIAL_EN
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic s;
`endif
    e.id = id; e.tag = r.tag; e.acc_cyc = c;
    e.nv = 1'b0; e.dz = 1'b0; e.lat = ITERS + 2; e.z = dp_model(r.a, r.b);
`ifdef FDIV_CTRL_SPECIAL_EN
    a_nan  = (r.a[30:23] == 8'hFF) && (r.a[22:0] != 0);
    b_nan  = (r.b[30:23] == 8'hFF) && (r.b[22:0] != 0);
    a_inf  = (r.a[30:0] == 31'h7F80_0000);
    b_inf  = (r.b[30:0] == 31'h7F80_0000);
    a_zero = (r.a[30:0] == 0);
    b_zero = (r.b[30:0] == 0);
    s = r.a[31] ^ r.b[31];
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      e.z = 32'h7FC0_0000; e.nv = 1'b1; e.lat = 1;
    end else if (a_inf) begin
      e.z = {s, 31'h7F80_0000}; e.lat = 1;
    end else if (b_zero) begin
      e.z = {s, 31'h7F80_0000}; e.dz = 1'b1; e.lat = 1;
    end else if (b_inf || a_zero) begin
      e.z = {s, 31'd0}; e.lat = 1;
    end
`endif
    return e;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return {1'($urandom), 31'd0};
      1:       return {1'($urandom), 8'hFF, 23'd0};
      2:       return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
      3:       return {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7FFFFF))};
      default: return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Request drivers: present the queue head until the monitor sees it taken.
  initial begin : drv0
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_tag = 0;
    forever begin
      @(posedge clk); #1;
      if (acc0) begin q0.delete(0); acc0 = 0; end
      if (q0.size() > 0) begin
        req0_valid = 1; req0_a = q0[0].a; req0_b = q0[0].b; req0_tag = q0[0].tag;
      end else begin
        req0_valid = 0; req0_a = $urandom; req0_b = $urandom; req0_tag = TAG_W'($urandom);
      end
    end
  end

  initial begin : drv1
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_tag = 0;
    forever begin
      @(posedge clk); #1;
      if (acc1) begin q1.delete(0); acc1 = 0; end
      if (q1.size() > 0) begin
        req1_valid = 1; req1_a = q1[0].a; req1_b = q1[0].b; req1_tag = q1[0].tag;
      end else begin
        req1_valid = 0; req1_a = $urandom; req1_b = $urandom; req1_tag = TAG_W'($urandom);
      end
    end
  end

  initial begin : drv_rr
    res_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = ($urandom_range(0, 2) != 0);
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pushes expectations on acceptance, pops and checks on results.
  initial begin : mon
    logic             id, rr_fav, hold, have_dp, took;
    logic [31:0]      hz, exp_a, exp_b;
    logic [TAG_W-1:0] htag;
    logic             hid, hnv, hdz;
    int               n_load, n_step;
    exp_t             e;
    req_t             r;
    rr_fav = 0; hold = 0; have_dp = 0; n_load = 0; n_step = 0;
    hz = 0; htag = 0; hid = 0; hnv = 0; hdz = 0; exp_a = 0; exp_b = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete(); rr_fav = 0; hold = 0;
      end else begin
        if (have_dp) begin
          chk("dp_a_stable", dp_a, exp_a);
          chk("dp_b_stable", dp_b, exp_b);
        end
        if (busy) chk("ready_while_busy", 32'(req0_ready | req1_ready), 32'd0);
        if (dp_load) n_load++;
        if (dp_step) n_step++;
        took = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        if (took) begin
          id = req1_valid && req1_ready;
          if (req0_valid && req1_valid) chk("rr_grant", 32'(id), 32'(rr_fav));
          rr_fav = !id;
          r.a   = id ? req1_a   : req0_a;
          r.b   = id ? req1_b   : req0_b;
          r.tag = id ? req1_tag : req0_tag;
          sb.push_back(model(r, id, cyc));
          acclog.push_back(id);
          if (id) acc1 = 1; else acc0 = 1;
          exp_a = r.a; exp_b = r.b; have_dp = 1;
          n_load = 0; n_step = 0;
        end
        if (res_valid) begin
          chk("strobe_in_done", {30'd0, dp_load, dp_step}, 32'd0);
          if (!hold) begin
            if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
            else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
          end else begin
            chk("hold_z", res_z, hz);
            chk("hold_tag", 32'(res_tag), 32'(htag));
            chk("hold_id_flags", {29'd0, res_id, res_nv, res_dz}, {29'd0, hid, hnv, hdz});
          end
          hz = res_z; htag = res_tag; hid = res_id; hnv = res_nv; hdz = res_dz;
          if (res_ready && sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_z", res_z, e.z);
            chk("res_id", 32'(res_id), 32'(e.id));
            chk("res_tag", 32'(res_tag), 32'(e.tag));
            chk("res_nv", 32'(res_nv), 32'(e.nv));
            chk("res_dz", 32'(res_dz), 32'(e.dz));
            chk("load_count", 32'(n_load), (e.lat == 1) ? 32'd0 : 32'd1);
            chk("step_count", 32'(n_step), (e.lat == 1) ? 32'd0 : 32'(ITERS));
            zlog.push_back(res_z); idlog.push_back(res_id); taglog.push_back(res_tag);
            nvlog.push_back(res_nv); dzlog.push_back(res_dz);
          end
          hold = !res_ready;
        end else begin
          if (hold) chk("valid_held", 32'd0, 32'd1);
          hold = 0;
        end
      end
    end
  end

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (q0.size() == 0) && (q1.size() == 0) && (sb.size() == 0) && !busy &&
             !req0_valid && !req1_valid && !rst;
    end
    chk("drain_timeout", 32'(!done), 32'd0);
  endtask

  task automatic clear_logs();
    zlog.delete(); idlog.delete(); taglog.delete(); nvlog.delete(); dzlog.delete(); acclog.delete();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    req_t r;
    bit   seen;
    rst = 1;
    // Normal divide queued during reset: ready must stay low regardless.
    r.a = 32'h40C0_0000; r.b = 32'h4000_0000; r.tag = 4'd5;
    q0.push_back(r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_strobes", {30'd0, dp_load, dp_step}, 32'd0);
    chk("rst_valid_busy", {30'd0, res_valid, busy}, 32'd0);
    chk("rst_res_z", res_z, 32'd0);
    chk("rst_res_tag_id", {27'd0, res_tag, res_id}, 32'd0);
    chk("rst_flags", {30'd0, res_nv, res_dz}, 32'd0);
    @(posedge clk); #1 rst = 0;

    // Normal divide
    drain(200);
    chk("normal_count", 32'(zlog.size()), 32'd1);
    if (zlog.size() == 1) begin
      chk("normal_z", zlog[0], 32'h4040_0000);
      chk("normal_id", 32'(idlog[0]), 32'd0);
      chk("normal_tag", 32'(taglog[0]), 32'd5);
    end

    // Contention: two pairs queued during reset, released together
    @(posedge clk); #2 rst = 1;
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      r.a = 32'h3F80_0000 + 32'(i); r.b = 32'h4000_0000; r.tag = TAG_W'(i);
      if (i % 2 == 0) q0.push_back(r); else q1.push_back(r);
    end
    repeat (2) @(posedge clk);
    #2 rst = 0;
    drain(300);
    chk("contention_count", 32'(acclog.size()), 32'd4);
    if (acclog.size() == 4)
      chk("contention_order", {28'd0, acclog[0], acclog[1], acclog[2], acclog[3]}, 32'b0101);

    // Backpressure: result held for 4 cycles with req0 waiting
    rr_mode = 2;
    r.a = 32'h4110_0000; r.b = 32'h4040_0000; r.tag = 4'hA;
    q1.push_back(r);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = res_valid; end
    chk("bp_valid_seen", 32'(seen), 32'd1);
    r.a = 32'h4000_0000; r.b = 32'h3F80_0000; r.tag = 4'h3;
    q0.push_back(r);
    repeat (4) @(negedge clk);
    chk("bp_still_valid", 32'(res_valid), 32'd1);
    chk("bp_ready0", 32'(req0_ready), 32'd0);
    rr_mode = 0;
    drain(200);

    // Special operands: 1.0/0.0 and 0/0
    clear_logs();
    r.a = 32'h3F80_0000; r.b = 32'h0000_0000; r.tag = 4'd1; q0.push_back(r);
    r.a = 32'h0000_0000; r.b = 32'h0000_0000; r.tag = 4'd2; q0.push_back(r);
    drain(200);
    chk("special_count", 32'(zlog.size()), 32'd2);
    if (zlog.size() == 2) begin
`ifdef FDIV_CTRL_SPECIAL_EN
      chk("one_over_zero_z", zlog[0], 32'h7F80_0000);
      chk("one_over_zero_flags", {30'd0, nvlog[0], dzlog[0]}, 32'b01);
      chk("zero_over_zero_z", zlog[1], 32'h7FC0_0000);
      chk("zero_over_zero_flags", {30'd0, nvlog[1], dzlog[1]}, 32'b10);
`else
      chk("one_over_zero_z", zlog[0], dp_model(32'h3F80_0000, 32'h0));
      chk("one_over_zero_flags", {30'd0, nvlog[0], dzlog[0]}, 32'd0);
      chk("zero_over_zero_z", zlog[1], dp_model(32'h0, 32'h0));
      chk("zero_over_zero_flags", {30'd0, nvlog[1], dzlog[1]}, 32'd0);
`endif
    end

    // Reset in the second ITER cycle
    clear_logs();
    r.a = 32'h4120_0000; r.b = 32'h4080_0000; r.tag = 4'd7; q0.push_back(r);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = dp_step; end
    chk("mid_iter_step_seen", 32'(seen), 32'd1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_step", 32'(dp_step), 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", 32'(res_valid), 32'd0);
    end
    r.a = 32'h4140_0000; r.b = 32'h4000_0000; r.tag = 4'd9; q0.push_back(r);
    drain(200);
    chk("after_rst_count", 32'(zlog.size()), 32'd1);
    if (zlog.size() == 1) chk("after_rst_tag", 32'(taglog[0]), 32'd9);

    // Randomized traffic with random backpressure
    rr_mode = 1;
    for (int i = 0; i < 60; i++) begin
      r.a = rand_op(); r.b = rand_op(); r.tag = TAG_W'($urandom);
      if ($urandom_range(0, 1) == 1) q1.push_back(r); else q0.push_back(r);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 12)) @(posedge clk);
    end
    drain(5000);
    rr_mode = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
